// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants and types for the VGA frame streamer.
//   - Default 640x480@60 raster timing and derived totals.
//   - Stream FSM state type.
//   - Pixel word / grey / pop-counter widths.
//   - in_window(): inclusive range test used for the sync windows.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Pops in one fully streamed frame at the default timing.
  localparam int unsigned PIXELS_PER_FRAME = 307200;

  localparam int unsigned PIX_W     = 10;
  localparam int unsigned GREY_W    = 8;
  localparam int unsigned POP_CNT_W = 19;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stream_state_t;

  // Inclusive window test; callers cast their counters to 16 bits.
  function automatic logic in_window(input logic [15:0] val,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Free-running raster counters for the VGA pixel clock domain.
// Ports:
//   clk           in   pixel clock
//   portV_arst    in   asynchronous active-high reset (counters -> (0,0))
//   hs_n_o        out  horizontal sync, active-low, combinational from hcnt
//   vs_n_o        out  vertical sync, active-low, combinational from vcnt
//   active_o      out  counters are inside the visible area
//   wrap_o        out  counters at the last position; next edge wraps to (0,0)
//   frame_start_o out  counters currently read (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic clk,
  input  logic portV_arst,
  output logic hs_n_o,
  output logic vs_n_o,
  output logic active_o,
  output logic wrap_o,
  output logic frame_start_o
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCW      = $clog2(H_TOTAL);
  localparam int unsigned VCW      = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic [VCW-1:0] vcnt_q, vcnt_d;
  logic           h_last_s;
  logic           v_last_s;

  // Counter next-state: hcnt wraps after H_TOTAL-1 and advances vcnt on that edge.
  always_comb begin
    h_last_s = (hcnt_q == HCW'(H_TOTAL - 1));
    v_last_s = (vcnt_q == VCW'(V_TOTAL - 1));
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    if (h_last_s) begin
      hcnt_d = '0;
      if (v_last_s) begin
        vcnt_d = '0;
      end else begin
        vcnt_d = vcnt_q + VCW'(1);
      end
    end else begin
      hcnt_d = hcnt_q + HCW'(1);
    end
  end

  // Counter registers; reset places the raster at (0,0).
  always_ff @(posedge clk or posedge portV_arst) begin
    if (portV_arst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Sync windows, visible-area flag and frame markers decoded from the counters.
  always_comb begin
    hs_n_o        = ~in_window(16'(hcnt_q), 16'(HS_START), 16'(HS_END));
    vs_n_o        = ~in_window(16'(vcnt_q), 16'(VS_START), 16'(VS_END));
    active_o      = (hcnt_q < HCW'(H_ACTIVE)) && (vcnt_q < VCW'(V_ACTIVE));
    wrap_o        = h_last_s && v_last_s;
    frame_start_o = (hcnt_q == '0) && (vcnt_q == '0);
  end

endmodule

// File: rtl/vga_frame_streamer.sv
// ---------------------------------------------------------------------------
// vga_frame_streamer
// Pops one 10-bit word per visible pixel from the VGA read port and drives the
// DAC with 8-bit grey, aligned to delayed sync/blank (2-clock latency).
// Ports:
//   clk            in   pixel clock (same net as the port block's portV_clk)
//   portV_arst     in   asynchronous active-high reset, shared with port block
//   run            in   streaming request, sampled only at the frame wrap
//   portV_dout     in   pixel word, valid the cycle after portV_nextDout
//   portV_nextDout out  pop request (combinational from state and counters)
//   VGA_R/G/B      out  grey colour, zero outside streamed visible pixels
//   VGA_HS/VS      out  active-low syncs
//   VGA_BLANK_N    out  high on visible pixels of a streamed frame
//   VGA_SYNC_N     out  tied low
//   frame_start    out  counters at (0,0), not delayed
//   frame_pops     out  pops counted in the last completed frame
// ---------------------------------------------------------------------------
module vga_frame_streamer
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic                 clk,
  input  logic                 portV_arst,
  input  logic                 run,
  input  logic [PIX_W-1:0]     portV_dout,
  output logic                 portV_nextDout,
  output logic [GREY_W-1:0]    VGA_R,
  output logic [GREY_W-1:0]    VGA_G,
  output logic [GREY_W-1:0]    VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK_N,
  output logic                 VGA_SYNC_N,
  output logic                 frame_start,
  output logic [POP_CNT_W-1:0] frame_pops
);

  stream_state_t        state_q, state_d;
  logic                 hs_n_s, vs_n_s, in_active_s, wrap_s, frame_start_s;
  logic                 active0_s;

  // Stage 1 carries the pixel decoded while its pop is outstanding; stage 2 is
  // the output register loaded together with the captured colour.
  logic                 act1_q, hs1_q, vs1_q;
  logic                 act2_q, hs2_q, vs2_q;
  logic [GREY_W-1:0]    grey_q, grey_d;

  logic [POP_CNT_W-1:0] pop_cnt_q, pop_cnt_d;
  logic [POP_CNT_W-1:0] frame_pops_q, frame_pops_d;

  // The two LSBs are dropped by the grey expansion.
  logic [1:0]           dout_lsb_unused_s;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk           (clk),
    .portV_arst    (portV_arst),
    .hs_n_o        (hs_n_s),
    .vs_n_o        (vs_n_s),
    .active_o      (in_active_s),
    .wrap_o        (wrap_s),
    .frame_start_o (frame_start_s)
  );

  // Stream state register.
  always_ff @(posedge clk or posedge portV_arst) begin
    if (portV_arst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // run only matters on the wrap edge, so a frame is always streamed whole.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wrap_s && run) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (wrap_s && !run) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop whenever a streamed frame is inside the visible area.
  always_comb begin
    active0_s         = (state_q == RUN) && in_active_s;
    dout_lsb_unused_s = portV_dout[1:0];
  end

  // Colour capture: the word for a pixel arrives one cycle after its pop, which
  // is exactly when that pixel's stage-1 active flag is set.
  always_comb begin
    if (act1_q) begin
      grey_d = portV_dout[PIX_W-1:2];
    end else begin
      grey_d = '0;
    end
  end

  // Two-stage alignment pipeline for active, syncs and colour.
  always_ff @(posedge clk or posedge portV_arst) begin
    if (portV_arst) begin
      act1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      act2_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      grey_q <= '0;
    end else begin
      act1_q <= active0_s;
      hs1_q  <= hs_n_s;
      vs1_q  <= vs_n_s;
      act2_q <= act1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      grey_q <= grey_d;
    end
  end

  // Pop counter; the wrap position is blanking, so no pop competes with the clear.
  always_comb begin
    pop_cnt_d    = pop_cnt_q;
    frame_pops_d = frame_pops_q;
    if (wrap_s) begin
      frame_pops_d = pop_cnt_q;
      pop_cnt_d    = '0;
    end else if (active0_s) begin
      pop_cnt_d = pop_cnt_q + POP_CNT_W'(1);
    end else begin
      pop_cnt_d = pop_cnt_q;
    end
  end

  // Pop counter and last-frame result registers.
  always_ff @(posedge clk or posedge portV_arst) begin
    if (portV_arst) begin
      pop_cnt_q    <= '0;
      frame_pops_q <= '0;
    end else begin
      pop_cnt_q    <= pop_cnt_d;
      frame_pops_q <= frame_pops_d;
    end
  end

  assign portV_nextDout = active0_s;
  assign VGA_R          = grey_q;
  assign VGA_G          = grey_q;
  assign VGA_B          = grey_q;
  assign VGA_HS         = hs2_q;
  assign VGA_VS         = vs2_q;
  assign VGA_BLANK_N    = act2_q;
  assign VGA_SYNC_N     = 1'b0;
  assign frame_start    = frame_start_s;
  assign frame_pops     = frame_pops_q;

endmodule

// File: tb/tb_vga_frame_streamer.sv
// Directed bench for vga_frame_streamer, using a reduced raster (16x10 total,
// 8x6 visible) so several whole frames fit in a short run.
module tb_vga_frame_streamer;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 6, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;   // 16
  localparam int VT = VA + VF + VSW + VB;   // 10
  localparam int FT = HT * VT;              // 160 clocks per frame
  localparam int PIX = HA * VA;             // 48 pops per streamed frame

  logic        clk = 1'b0;
  logic        portV_arst;
  logic        run;
  logic [9:0]  portV_dout;
  logic        portV_nextDout;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
  logic [18:0] frame_pops;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   pop_idx = 0;
  logic pop_pending = 1'b0;

  always #5 clk = ~clk;

  vga_frame_streamer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut (
    .clk            (clk),
    .portV_arst     (portV_arst),
    .run            (run),
    .portV_dout     (portV_dout),
    .portV_nextDout (portV_nextDout),
    .VGA_R          (VGA_R),
    .VGA_G          (VGA_G),
    .VGA_B          (VGA_B),
    .VGA_HS         (VGA_HS),
    .VGA_VS         (VGA_VS),
    .VGA_BLANK_N    (VGA_BLANK_N),
    .VGA_SYNC_N     (VGA_SYNC_N),
    .frame_start    (frame_start),
    .frame_pops     (frame_pops)
  );

  // Word handed out on the k-th pop of a frame.
  function automatic logic [9:0] word_of(input int k);
    if (k == 0) return 10'h3FC;
    else if (k == 1) return 10'h004;
    else return {8'(k * 37 + 11), 2'b01};
  endfunction

  function automatic int hpos(input int c); return c % HT; endfunction
  function automatic int vpos(input int c); return (c / HT) % VT; endfunction
  function automatic int fnum(input int c); return c / FT; endfunction

  // Expected output for the pixel two clocks before cycle c.
  function automatic logic exp_blank_n(input int c, input logic streamed);
    if (c < 2) return 1'b0;
    return streamed && (hpos(c - 2) < HA) && (vpos(c - 2) < VA);
  endfunction

  function automatic logic [7:0] exp_grey(input int c, input logic streamed);
    logic [9:0] w;
    if (!exp_blank_n(c, streamed)) return 8'h00;
    w = word_of(vpos(c - 2) * HA + hpos(c - 2));
    return w[9:2];
  endfunction

  function automatic logic exp_hs(input int c);
    if (c < 2) return 1'b1;
    return !((hpos(c - 2) >= HA + HF) && (hpos(c - 2) <= HA + HF + HSW - 1));
  endfunction

  function automatic logic exp_vs(input int c);
    if (c < 2) return 1'b1;
    return !((vpos(c - 2) >= VA + VF) && (vpos(c - 2) <= VA + VF + VSW - 1));
  endfunction

  // Port FIFO model: a pop seen in one cycle yields a word early in the next.
  always @(negedge clk) begin
    if (frame_start) pop_idx = 0;
    pop_pending = portV_nextDout;
  end

  always @(posedge clk) begin
    #1;
    if (pop_pending) begin
      portV_dout = word_of(pop_idx);
      pop_idx++;
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input logic run_v);
    portV_arst = 1'b1;
    run = run_v;
    repeat (2) @(negedge clk);
    portV_arst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    portV_arst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    vectors++; if (VGA_HS !== 1'b1) begin miscompares++; $display("FAIL reset_hs: got %b want 1", VGA_HS); end
    vectors++; if (VGA_VS !== 1'b1) begin miscompares++; $display("FAIL reset_vs: got %b want 1", VGA_VS); end
    vectors++; if (VGA_BLANK_N !== 1'b0) begin miscompares++; $display("FAIL reset_blank: got %b want 0", VGA_BLANK_N); end
    vectors++; if (VGA_R !== 8'h00 || VGA_G !== 8'h00 || VGA_B !== 8'h00) begin miscompares++; $display("FAIL reset_rgb: got %h %h %h want 00", VGA_R, VGA_G, VGA_B); end
    vectors++; if (portV_nextDout !== 1'b0) begin miscompares++; $display("FAIL reset_pop: got %b want 0", portV_nextDout); end
    vectors++; if (frame_pops !== 19'd0) begin miscompares++; $display("FAIL reset_frame_pops: got %0d want 0", frame_pops); end
    vectors++; if (VGA_SYNC_N !== 1'b0) begin miscompares++; $display("FAIL reset_sync_n: got %b want 0", VGA_SYNC_N); end
    vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL reset_frame_start: got %b want 1", frame_start); end
  endtask

  // run held high: frame 0 idles (no boundary seen yet), frames 1 and 2 stream.
  task automatic test_stream();
    int line_pops = 0;
    do_reset(1'b1);
    for (int i = 0; i < 3 * FT + 2; i++) begin
      logic       strm;
      logic       eb;
      logic [7:0] eg;
      int         exp_lp;
      int         exp_fp;
      if (portV_nextDout === 1'b1) line_pops++;
      if (hpos(cyc) == HT - 1) begin
        exp_lp = (fnum(cyc) >= 1 && vpos(cyc) < VA) ? HA : 0;
        vectors++;
        if (line_pops != exp_lp) begin miscompares++; $display("FAIL line_pops c=%0d: got %0d want %0d", cyc, line_pops, exp_lp); end
        line_pops = 0;
      end
      strm = (fnum(cyc - 2) >= 1);
      eb = exp_blank_n(cyc, strm);
      eg = exp_grey(cyc, strm);
      vectors++;
      if (VGA_BLANK_N !== eb) begin miscompares++; $display("FAIL blank_n c=%0d: got %b want %b", cyc, VGA_BLANK_N, eb); end
      vectors++;
      if (VGA_R !== eg || VGA_G !== eg || VGA_B !== eg) begin miscompares++; $display("FAIL rgb c=%0d: got %h %h %h want %h", cyc, VGA_R, VGA_G, VGA_B, eg); end
      vectors++;
      if (frame_start !== (cyc % FT == 0)) begin miscompares++; $display("FAIL frame_start c=%0d: got %b want %b", cyc, frame_start, (cyc % FT == 0)); end
      if (cyc == FT || cyc == 2 * FT || cyc == 3 * FT) begin
        exp_fp = (cyc == FT) ? 0 : PIX;
        vectors++;
        if (frame_pops !== 19'(exp_fp)) begin miscompares++; $display("FAIL frame_pops c=%0d: got %0d want %0d", cyc, frame_pops, exp_fp); end
      end
      if (cyc == FT + 2) begin
        vectors++;
        if (VGA_R !== 8'hFF) begin miscompares++; $display("FAIL pixel00: got %h want ff", VGA_R); end
      end
      if (cyc == FT + 3) begin
        vectors++;
        if (VGA_R !== 8'h01) begin miscompares++; $display("FAIL pixel10: got %h want 01", VGA_R); end
      end
      tick();
    end
  endtask

  // Syncs in IDLE: HS low for HSW clocks from output cycle HA+HF+2, VS for VSW lines.
  task automatic test_sync();
    int first_hs = -1;
    int hs_lows = 0;
    int vs_lows = 0;
    int pops = 0;
    do_reset(1'b0);
    for (int i = 0; i < FT + 2; i++) begin
      if (VGA_HS === 1'b0 && cyc < HT + 2) begin
        hs_lows++;
        if (first_hs < 0) first_hs = cyc;
      end
      if (VGA_VS === 1'b0) vs_lows++;
      if (portV_nextDout === 1'b1) pops++;
      vectors++;
      if (VGA_HS !== exp_hs(cyc)) begin miscompares++; $display("FAIL hs c=%0d: got %b want %b", cyc, VGA_HS, exp_hs(cyc)); end
      vectors++;
      if (VGA_VS !== exp_vs(cyc)) begin miscompares++; $display("FAIL vs c=%0d: got %b want %b", cyc, VGA_VS, exp_vs(cyc)); end
      tick();
    end
    vectors++; if (first_hs != HA + HF + 2) begin miscompares++; $display("FAIL hs_start: got %0d want %0d", first_hs, HA + HF + 2); end
    vectors++; if (hs_lows != HSW) begin miscompares++; $display("FAIL hs_width: got %0d want %0d", hs_lows, HSW); end
    vectors++; if (vs_lows != VSW * HT) begin miscompares++; $display("FAIL vs_width: got %0d want %0d", vs_lows, VSW * HT); end
    vectors++; if (pops != 0) begin miscompares++; $display("FAIL idle_pops: got %0d want 0", pops); end
  endtask

  // run drops mid-frame 1 and pulses inside frame 2: frame 1 completes, 2 and 3 idle.
  task automatic test_run_drop();
    int pops_f[4] = '{0, 0, 0, 0};
    int blank_hi = 0;
    do_reset(1'b1);
    for (int i = 0; i < 3 * FT + 10; i++) begin
      if (cyc == FT + 40) run = 1'b0;
      if (cyc == 2 * FT + 50) run = 1'b1;
      if (cyc == 2 * FT + 60) run = 1'b0;
      if (portV_nextDout === 1'b1) pops_f[fnum(cyc)]++;
      if (cyc >= 2 * FT + 2 && VGA_BLANK_N !== 1'b0) blank_hi++;
      if (cyc == 2 * FT) begin
        vectors++;
        if (frame_pops !== 19'(PIX)) begin miscompares++; $display("FAIL drop_frame_pops1: got %0d want %0d", frame_pops, PIX); end
      end
      if (cyc == 3 * FT) begin
        vectors++;
        if (frame_pops !== 19'd0) begin miscompares++; $display("FAIL drop_frame_pops2: got %0d want 0", frame_pops); end
      end
      tick();
    end
    vectors++; if (pops_f[1] != PIX) begin miscompares++; $display("FAIL drop_pops_f1: got %0d want %0d", pops_f[1], PIX); end
    vectors++; if (pops_f[2] != 0) begin miscompares++; $display("FAIL drop_pops_f2: got %0d want 0", pops_f[2]); end
    vectors++; if (pops_f[3] != 0) begin miscompares++; $display("FAIL drop_pops_f3: got %0d want 0", pops_f[3]); end
    vectors++; if (blank_hi != 0) begin miscompares++; $display("FAIL drop_blank: got %0d want 0", blank_hi); end
  endtask

  // Reset at pixel (3,2) of streamed frame 2; the next pop comes a full frame after release.
  task automatic test_midframe_reset();
    int first_pop = -1;
    do_reset(1'b1);
    while (cyc < 2 * FT + 2 * HT + 3) tick();
    vectors++; if (portV_nextDout !== 1'b1) begin miscompares++; $display("FAIL pre_reset_pop: got %b want 1", portV_nextDout); end
    vectors++; if (frame_pops !== 19'(PIX)) begin miscompares++; $display("FAIL pre_reset_frame_pops: got %0d want %0d", frame_pops, PIX); end
    portV_arst = 1'b1;
    #1;
    vectors++; if (portV_nextDout !== 1'b0) begin miscompares++; $display("FAIL arst_pop: got %b want 0", portV_nextDout); end
    vectors++; if (VGA_BLANK_N !== 1'b0) begin miscompares++; $display("FAIL arst_blank: got %b want 0", VGA_BLANK_N); end
    vectors++; if (VGA_R !== 8'h00 || VGA_G !== 8'h00 || VGA_B !== 8'h00) begin miscompares++; $display("FAIL arst_rgb: got %h %h %h want 00", VGA_R, VGA_G, VGA_B); end
    vectors++; if (VGA_HS !== 1'b1 || VGA_VS !== 1'b1) begin miscompares++; $display("FAIL arst_sync: got %b %b want 1 1", VGA_HS, VGA_VS); end
    vectors++; if (frame_pops !== 19'd0) begin miscompares++; $display("FAIL arst_frame_pops: got %0d want 0", frame_pops); end
    vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL arst_frame_start: got %b want 1", frame_start); end
    @(negedge clk);
    portV_arst = 1'b0;
    cyc = 0;
    for (int i = 0; i < FT + 20; i++) begin
      if (portV_nextDout === 1'b1 && first_pop < 0) first_pop = cyc;
      tick();
    end
    vectors++; if (first_pop != FT) begin miscompares++; $display("FAIL first_pop_after_reset: got %0d want %0d", first_pop, FT); end
  endtask

  initial begin
    portV_arst = 1'b1;
    run = 1'b0;
    portV_dout = 10'h000;
    test_reset();
    test_stream();
    test_sync();
    test_run_drop();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
